// File: rtl/nrisc_pkg.sv
// Shared encodings for the nRISC multi-cycle control FSM: states, opcodes,
// ALU and PC-source selects, and the bundle of control strobes.
package nrisc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [7:0] HALT_INSTR = 8'hFF;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       busy;
    logic       error;
  } ctrl_t;

  function automatic logic is_rtype(input logic [2:0] opcode);
    return opcode[2] == 1'b0;
  endfunction

endpackage

// File: rtl/nrisc_wait_timer.sv
// Counts consecutive memory-not-ready cycles; expired flags the last
// tolerated cycle so the FSM can divert to ERR on the following edge.
module nrisc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [7:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= 8'd0;
    end else if (count_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/nrisc_control_fsm.sv
// Multi-cycle control FSM for the 8-bit nRISC core. Define NRISC_HALT_EN to
// decode instr 8'hFF as a HALT; otherwise it executes as an ordinary JMP.
module nrisc_control_fsm
  import nrisc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       busy,
  output logic       error,
  output logic [2:0] state
);

`ifdef NRISC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_t     r_state;
  state_t     w_next;
  ctrl_t      w_ctrl;
  logic       w_count_en;
  logic       w_expired;
  logic       w_clear;
  logic [2:0] w_opcode;

  assign w_opcode = instr[7:5];
  assign w_clear  = (w_next != r_state);

  nrisc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_clear),
    .count_en(w_count_en),
    .expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_ctrl     = '0;
    w_count_en = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_ctrl.busy     = 1'b1;
        w_ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PC_INC;
          w_next          = ST_DECODE;
        end else begin
          w_count_en = 1'b1;
          if (w_expired) w_next = ST_ERR;
        end
      end
      ST_DECODE: begin
        w_ctrl.busy = 1'b1;
        if (HALT_EN && instr == HALT_INSTR) begin
          w_next = ST_HALT;
        end else if (w_opcode == OP_JMP) begin
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PC_JUMP;
          w_next          = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_ctrl.busy = 1'b1;
        if (is_rtype(w_opcode)) begin
          w_ctrl.alu_op = w_opcode[1:0];
          w_next        = ST_WB;
        end else if (w_opcode == OP_LW || w_opcode == OP_SW) begin
          w_ctrl.alu_src = 1'b1;
          w_ctrl.alu_op  = ALU_ADD;
          w_next         = ST_MEM;
        end else if (w_opcode == OP_BEQ) begin
          w_ctrl.alu_op   = ALU_SUB;
          w_ctrl.pc_src   = PC_BRANCH;
          w_ctrl.pc_write = zero;
          w_next          = ST_FETCH;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        w_ctrl.busy      = 1'b1;
        w_ctrl.mem_read  = (w_opcode == OP_LW);
        w_ctrl.mem_write = (w_opcode == OP_SW);
        if (mem_ready) begin
          w_next = (w_opcode == OP_LW) ? ST_WB : ST_FETCH;
        end else begin
          w_count_en = 1'b1;
          if (w_expired) w_next = ST_ERR;
        end
      end
      ST_WB: begin
        w_ctrl.busy       = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = (w_opcode == OP_LW);
        w_next            = ST_FETCH;
      end
      ST_ERR: begin
        w_ctrl.error = 1'b1;
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (reset) w_ctrl = '0;
  end

  assign pc_write   = w_ctrl.pc_write;
  assign pc_src     = w_ctrl.pc_src;
  assign ir_write   = w_ctrl.ir_write;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign reg_write  = w_ctrl.reg_write;
  assign alu_op     = w_ctrl.alu_op;
  assign alu_src    = w_ctrl.alu_src;
  assign busy       = w_ctrl.busy;
  assign error      = w_ctrl.error;
  assign state      = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_nrisc_control_fsm.sv
// Directed bench for nrisc_control_fsm (WAIT_MAX=4): instruction paths,
// wait timeout, ready-wins, halt/jump on 8'hFF and reset mid-MEM.
module tb_nrisc_control_fsm;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] instr;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_op;
  logic       alu_src;
  logic       busy;
  logic       error;
  logic [2:0] state;

  int n_total = 0;
  int n_bad   = 0;

  nrisc_control_fsm #(
    .WAIT_MAX(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .reg_write (reg_write),
    .alu_op    (alu_op),
    .alu_src   (alu_src),
    .busy      (busy),
    .error     (error),
    .state     (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // {pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg, reg_write,
  //  alu_op, alu_src, busy, error, state}
  function automatic logic [15:0] outs();
    return {pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
            reg_write, alu_op, alu_src, busy, error, state};
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = 8'h00; zero = 1'b0; mem_ready = 1'b0;
    #1 check("rst_outs", outs(), 16'h0000);
    tick(); tick();
    check("rst_hold", outs(), 16'h0000);
    reset = 1'b0;
    #1 check("idle_after_rst", outs(), 16'h0000);

    // ADD: start held high throughout to show it is ignored while busy
    instr = 8'h05; mem_ready = 1'b1; start = 1'b1;
    #1 check("idle_busy", {15'd0, busy}, 16'd0);
    tick(); check("add_fetch", outs(), 16'h9811);
    tick(); check("add_dec_st", {13'd0, state}, 16'd2);
            check("add_dec_pcw", {15'd0, pc_write}, 16'd0);
    tick(); check("add_exec_st", {13'd0, state}, 16'd3);
            check("add_exec_aluop", {14'd0, alu_op}, 16'd0);
            check("add_exec_rw", {15'd0, reg_write}, 16'd0);
    tick(); check("add_wb_st", {13'd0, state}, 16'd5);
            check("add_wb_rw", {15'd0, reg_write}, 16'd1);
            check("add_wb_m2r", {15'd0, mem_to_reg}, 16'd0);
    tick(); check("add_ret_st", {13'd0, state}, 16'd1);

    // LW with three not-ready cycles in MEM
    start = 1'b0; instr = 8'h80;
    tick(); check("lw_dec_st", {13'd0, state}, 16'd2);
    tick(); check("lw_exec_src", {15'd0, alu_src}, 16'd1);
            check("lw_exec_aluop", {14'd0, alu_op}, 16'd0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_mem_wait", {12'd0, mem_read, state}, {12'd0, 1'b1, 3'd4});
    end
    mem_ready = 1'b1;
    #1 check("lw_mem_rdy", {11'd0, error, mem_read, state},
             {11'd0, 1'b0, 1'b1, 3'd4});
    tick(); check("lw_wb", {12'd0, error, reg_write, mem_to_reg, 1'b0},
                  {12'd0, 1'b0, 1'b1, 1'b1, 1'b0});
            check("lw_wb_st", {13'd0, state}, 16'd5);
    tick(); check("lw_ret_st", {13'd0, state}, 16'd1);

    // BEQ taken then not taken
    instr = 8'hC0; zero = 1'b1;
    tick(); tick();
    check("beq1_exec", {11'd0, pc_write, pc_src, alu_op},
          {11'd0, 1'b1, 2'b01, 2'b01});
    tick(); check("beq1_ret_st", {13'd0, state}, 16'd1);
    zero = 1'b0;
    tick(); tick();
    check("beq0_exec", {12'd0, pc_write, state}, {12'd0, 1'b0, 3'd3});
    tick(); check("beq0_ret_st", {13'd0, state}, 16'd1);

    // Timeout in FETCH: four not-ready cycles, then ERR
    mem_ready = 1'b0;
    #1 check("to_c1", {13'd0, state}, 16'd1);
    tick(); tick(); tick();
    check("to_c4", {12'd0, busy, state}, {12'd0, 1'b1, 3'd1});
    tick(); check("to_err", outs(), 16'h000E);
    start = 1'b1;
    tick(); tick();
    check("err_sticky", outs(), 16'h000E);
    reset = 1'b1;
    #1 check("err_rst_out", outs(), 16'h0000);
    tick();
    reset = 1'b0;
    #1 check("rel_idle", outs(), 16'h0000);
    tick(); check("rel_fetch", {13'd0, state}, 16'd1);
    start = 1'b0;

    // Ready arriving on the last tolerated cycle wins over the timeout
    instr = 8'h05;
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #1 check("rw_c4", {14'd0, ir_write, error}, {14'd0, 1'b1, 1'b0});
    tick(); check("rw_decode", {12'd0, error, state}, {12'd0, 1'b0, 3'd2});
    tick(); tick(); tick();
    check("rw_ret_st", {13'd0, state}, 16'd1);

    // 8'hFF: HALT when enabled, otherwise a plain JMP
    instr = 8'hFF;
    tick();
`ifdef NRISC_HALT_EN
    check("ff_dec", {12'd0, pc_write, state}, {12'd0, 1'b0, 3'd2});
    tick(); check("halt", outs(), 16'h0007);
    start = 1'b1;
    tick(); check("halt_hold", outs(), 16'h0007);
    start = 1'b0;
`else
    check("ff_jmp", {13'd0, pc_write, pc_src}, {13'd0, 1'b1, 2'b10});
    tick(); check("ff_jmp_ret", {13'd0, state}, 16'd1);
`endif

    // Reset asserted mid-MEM on a stalled SW
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b1; instr = 8'hA0; mem_ready = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick(); mem_ready = 1'b0;
    tick(); check("sw_mem", {11'd0, mem_write, mem_read, state},
                  {11'd0, 1'b1, 1'b0, 3'd4});
    reset = 1'b1;
    #1 check("sw_rst_out", outs(), 16'h0000);
    tick(); check("sw_rst_hold", outs(), 16'h0000);
    reset = 1'b0;
    #1 check("sw_rst_idle", outs(), 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
